// File: rtl/main_control_if.sv
// Signal bundle between the multicycle main control FSM and the datapath it steers:
// opcode/memory handshake in, datapath control strobes, debug state and retire count out.
interface main_control_if;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemtoReg;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        illegal_op;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state, instr_retired
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state, instr_retired
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle main control: sequences fetch/decode/execute/memory/write-back,
// Moore-decodes datapath controls from state and counts retired instructions.
module main_control_fsm (
  input  logic       clk,
  input  logic       reset,
  main_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      state_r, state_next_s;
  logic        is_store_r;
  logic [31:0] retired_r;
  logic        retire_s;
  logic        pc_write_s, pc_write_cond_s, iord_s, mem_read_s, mem_write_s, ir_write_s;
  logic        mem_to_reg_s, reg_dst_s, reg_write_s, alu_src_a_s, illegal_s;
  logic [1:0]  alu_src_b_s, alu_op_s, pc_source_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= FETCH;
    else       state_r <= state_next_s;
  end

  // Load/store choice is captured in DECODE so opcode only has to be valid there
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 is_store_r <= 1'b0;
    else if (state_r == DECODE) is_store_r <= (bus.opcode == OP_SW);
  end

  // Retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         retired_r <= 32'd0;
    else if (retire_s) retired_r <= retired_r + 32'd1;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_next_s    = FETCH;
    retire_s        = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    pc_source_s     = 2'b00;
    illegal_s       = 1'b0;
    case (state_r)
      FETCH: begin
        mem_read_s   = 1'b1;
        alu_src_b_s  = 2'b01;
        ir_write_s   = bus.mem_ready;
        pc_write_s   = bus.mem_ready;
        state_next_s = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_RTYPE:     state_next_s = EXEC;
          OP_BEQ:       state_next_s = BRANCH;
          OP_J:         state_next_s = JUMP;
          OP_ADDI:      state_next_s = ADDIEX;
          default: begin
            state_next_s = FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        state_next_s = is_store_r ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read_s   = 1'b1;
        iord_s       = 1'b1;
        state_next_s = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
      end
      MEMWR: begin
        mem_write_s  = 1'b1;
        iord_s       = 1'b1;
        retire_s     = bus.mem_ready;
        state_next_s = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b10;
        state_next_s = ALUWB;
      end
      ALUWB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
        retire_s        = 1'b1;
      end
      JUMP: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'b10;
        retire_s    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        state_next_s = ADDIWB;
      end
      ADDIWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      default: state_next_s = FETCH;
    endcase
  end

  // Controls are gated by reset so nothing is asserted while it is held
  assign bus.PCWrite       = pc_write_s      & ~reset;
  assign bus.PCWriteCond   = pc_write_cond_s & ~reset;
  assign bus.IorD          = iord_s          & ~reset;
  assign bus.MemRead       = mem_read_s      & ~reset;
  assign bus.MemWrite      = mem_write_s     & ~reset;
  assign bus.IRWrite       = ir_write_s      & ~reset;
  assign bus.MemtoReg      = mem_to_reg_s    & ~reset;
  assign bus.RegDst        = reg_dst_s       & ~reset;
  assign bus.RegWrite      = reg_write_s     & ~reset;
  assign bus.ALUSrcA       = alu_src_a_s     & ~reset;
  assign bus.ALUSrcB       = alu_src_b_s     & {2{~reset}};
  assign bus.ALUOp         = alu_op_s        & {2{~reset}};
  assign bus.PCSource      = pc_source_s     & {2{~reset}};
  assign bus.illegal_op    = illegal_s       & ~reset;
  assign bus.state         = state_r;
  assign bus.instr_retired = retired_r;
endmodule

// File: tb/tb_main_control_fsm.sv
// Directed self-checking bench for main_control_fsm: per-cycle state, control and
// retire-count checks against hand-written expectations.
module tb_main_control_fsm;
  logic clk = 1'b0;
  logic reset;
  main_control_if bus ();

  main_control_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  // Fields: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource illegal_op
  localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FETCHW = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] C_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  function automatic logic [16:0] ctl_now();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Check one cycle (inputs already applied), then advance to just after the next edge
  task automatic step(input string tag, input logic [3:0] st, input logic [16:0] ctl,
                      input logic [31:0] ret);
    #1;
    check_eq({tag, ".state"}, {28'd0, bus.state}, {28'd0, st});
    check_eq({tag, ".ctl"}, {15'd0, ctl_now()}, {15'd0, ctl});
    check_eq({tag, ".retired"}, bus.instr_retired, ret);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_R;
    @(posedge clk); #1;
    step("rst0", 4'd0, C_ZERO, 32'd0);
    step("rst1", 4'd0, C_ZERO, 32'd0);
    reset = 1'b0;

    // R-type
    step("r.f", 4'd0, C_FETCH, 32'd0);
    step("r.d", 4'd1, C_DECODE, 32'd0);
    step("r.ex", 4'd6, C_EXEC, 32'd0);
    step("r.wb", 4'd7, C_ALUWB, 32'd0);

    // lw with two wait cycles in MEMRD; opcode disturbed after decode
    bus.opcode = OP_LW;
    step("lw.f", 4'd0, C_FETCH, 32'd1);
    step("lw.d", 4'd1, C_DECODE, 32'd1);
    bus.opcode = OP_SW;
    step("lw.ma", 4'd2, C_MEMADR, 32'd1);
    bus.mem_ready = 1'b0;
    step("lw.rd0", 4'd3, C_MEMRD, 32'd1);
    step("lw.rd1", 4'd3, C_MEMRD, 32'd1);
    bus.mem_ready = 1'b1;
    step("lw.rd2", 4'd3, C_MEMRD, 32'd1);
    step("lw.wb", 4'd4, C_MEMWB, 32'd1);

    // sw with a FETCH wait and a MEMWR wait
    bus.opcode = OP_SW;
    bus.mem_ready = 1'b0;
    step("sw.fw", 4'd0, C_FETCHW, 32'd2);
    bus.mem_ready = 1'b1;
    step("sw.f", 4'd0, C_FETCH, 32'd2);
    step("sw.d", 4'd1, C_DECODE, 32'd2);
    bus.opcode = OP_LW;
    step("sw.ma", 4'd2, C_MEMADR, 32'd2);
    bus.mem_ready = 1'b0;
    step("sw.wr0", 4'd5, C_MEMWR, 32'd2);
    bus.mem_ready = 1'b1;
    step("sw.wr1", 4'd5, C_MEMWR, 32'd2);

    // beq: garbage opcode during FETCH has no effect
    bus.opcode = OP_BAD;
    step("beq.f", 4'd0, C_FETCH, 32'd3);
    bus.opcode = OP_BEQ;
    step("beq.d", 4'd1, C_DECODE, 32'd3);
    step("beq.br", 4'd8, C_BRANCH, 32'd3);

    bus.opcode = OP_J;
    step("j.f", 4'd0, C_FETCH, 32'd4);
    step("j.d", 4'd1, C_DECODE, 32'd4);
    step("j.j", 4'd9, C_JUMP, 32'd4);

    bus.opcode = OP_ADDI;
    step("addi.f", 4'd0, C_FETCH, 32'd5);
    step("addi.d", 4'd1, C_DECODE, 32'd5);
    step("addi.ex", 4'd10, C_MEMADR, 32'd5);
    step("addi.wb", 4'd11, C_ADDIWB, 32'd5);

    // Illegal opcode: two cycles, not counted
    bus.opcode = OP_BAD;
    step("ill.f", 4'd0, C_FETCH, 32'd6);
    step("ill.d", 4'd1, C_DECILL, 32'd6);

    // lw interrupted by reset while in MEMWB
    bus.opcode = OP_LW;
    step("lw2.f", 4'd0, C_FETCH, 32'd6);
    step("lw2.d", 4'd1, C_DECODE, 32'd6);
    step("lw2.ma", 4'd2, C_MEMADR, 32'd6);
    step("lw2.rd", 4'd3, C_MEMRD, 32'd6);
    #1;
    check_eq("lw2.wb.state", {28'd0, bus.state}, 32'd4);
    check_eq("lw2.wb.regwrite", {31'd0, bus.RegWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst.state", {28'd0, bus.state}, 32'd0);
    check_eq("midrst.ctl", {15'd0, ctl_now()}, {15'd0, C_ZERO});
    check_eq("midrst.retired", bus.instr_retired, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Counting resumes from zero
    bus.opcode = OP_J;
    step("j2.f", 4'd0, C_FETCH, 32'd0);
    step("j2.d", 4'd1, C_DECODE, 32'd0);
    step("j2.j", 4'd9, C_JUMP, 32'd0);
    step("end.f", 4'd0, C_FETCH, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the processor datapath. It sits directly upstream of the register file and ALU control. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives RegWrite, RegDst and MemtoReg for the register-file write port. It also drives ALUOp to ALU control and the PC, IR and memory enables. The memory handshake stretches fetch and memory states, and a retired-instruction counter supports verification.

## Interface
- No parameters; opcodes are fixed: R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, addi 6'b001000, j 6'b000010.
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- opcode  in  6  instruction[31:26] from IR, sampled in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  PC, memory and IR controls
- MemtoReg, RegDst, RegWrite  out  1 each  register-file write controls
- ALUSrcA  out  1;  ALUSrcB  out  2;  ALUOp  out  2;  PCSource  out  2
- illegal_op  out  1  one-cycle flag, unsupported opcode
- state  out  4  current state encoding, for debug
- instr_retired  out  32  count of completed instructions

## Operation
- State register (4 bits) encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Outputs are a Moore decode of state; only IRWrite and PCWrite in FETCH also depend on mem_ready. Any output not listed for a state is 0.
- FETCH
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: lw or sw → MEMADR; R-type → EXEC; beq → BRANCH; j → JUMP; addi → ADDIEX; any other opcode → FETCH with illegal_op=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1; waits for mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; then FETCH.
- MEMWR: MemWrite=1, IorD=1; waits for mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; then FETCH.
- JUMP: PCWrite=1, PCSource=10; then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; then ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; then FETCH.
- Unused encodings 12–15 drive all outputs 0 and go to FETCH on the next edge.
- instr_retired increments by 1, wrapping modulo 2^32, on every edge leaving MEMWB, MEMWR (with mem_ready=1), ALUWB, BRANCH, JUMP or ADDIWB. The illegal-opcode exit from DECODE does not count.
- Exactly one of MemRead or MemWrite, or neither, is ever asserted. RegWrite is asserted only in MEMWB, ALUWB and ADDIWB.

## Timing
- While reset=1: state=FETCH (0), instr_retired=0, and every control output is forced to 0.
- First FETCH output cycle is the first clock period after reset deasserts.
- Reset asserted mid-instruction immediately (asynchronously) returns state to FETCH and zeroes instr_retired. Any pending RegWrite or MemWrite drops in that same cycle.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs stay stable during the wait, and IRWrite/PCWrite stay 0 until mem_ready=1.
- opcode must be stable during DECODE only. Changes in other states have no effect.
- illegal_op is high for exactly the one DECODE cycle.

## Test plan
- Reset asserted, then released with mem_ready=1 → state 0, all outputs 0 during reset; next cycle MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type, mem_ready=1 → states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; ALUOp=10 in state 6; instr_retired 0→1.
- lw with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; MemtoReg=1 and RegWrite=1 in state 4; 7 cycles total.
- Sequence sw, beq, j, addi, all with mem_ready=1 → total 14 cycles; PCWriteCond=1 only in state 8; PCSource=10 in state 9; instr_retired=4.
- opcode 6'b111111 → states 0,1,0; illegal_op=1 for one cycle; RegWrite and MemWrite never 1; instr_retired unchanged.
- Reset pulsed while in MEMWB → RegWrite drops that cycle; state=0; instr_retired=0.
